// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the instruction-memory boot loader.
// Memory geometry is fixed here so every user agrees on address width.
// Byte cells only; the NOP pad byte is also defined here.
package imem_pkg;

  localparam int INSTR_MEM_SIZE = 256;
  localparam int MEM_CELL_SIZE  = 8;
  localparam int ADDR_W         = $clog2(INSTR_MEM_SIZE);

  localparam logic [MEM_CELL_SIZE-1:0] NOP_BYTE = 8'h00;

  // Largest acceptable program length, sized to the length/count width.
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(INSTR_MEM_SIZE);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PAD,
    DONE,
    ERR
  } boot_state_t;

endpackage

// File: rtl/imem_boot_loader.sv
// Boot loader: streams program bytes into instruction memory, pads to a word, then releases the CPU.
// Latency: memory write appears 1 cycle after a byte is accepted; release 1 cycle after the final write.
// Backpressure: byte_ready_o is high only in LOAD (state-only); the source is stalled during PAD/DONE/ERR/IDLE.
module imem_boot_loader
  import imem_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [ADDR_W:0]          prog_len_i,
  input  logic                     byte_valid_i,
  input  logic [MEM_CELL_SIZE-1:0] byte_data_i,
  output logic                     byte_ready_o,
  output logic                     mem_we_o,
  output logic [ADDR_W-1:0]        mem_waddr_o,
  output logic [MEM_CELL_SIZE-1:0] mem_wdata_o,
  output logic                     cpu_stall_o,
  output logic                     load_done_o,
  output logic                     load_err_o,
  output logic [7:0]               checksum_o
);

  boot_state_t              state_q, state_d;
  logic [ADDR_W:0]          len_q, len_d;
  logic [ADDR_W:0]          cnt_q, cnt_d;
  logic [ADDR_W:0]          cnt_inc;
  logic                     we_q, we_d;
  logic [ADDR_W-1:0]        waddr_q, waddr_d;
  logic [MEM_CELL_SIZE-1:0] wdata_q, wdata_d;
  logic                     stall_q, stall_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic [7:0]               csum_q, csum_d;

  assign cnt_inc = cnt_q + (ADDR_W + 1)'(1);

  // Ready depends on state only, never on byte_valid_i.
  assign byte_ready_o = (state_q == LOAD);

  assign mem_we_o    = we_q;
  assign mem_waddr_o = waddr_q;
  assign mem_wdata_o = wdata_q;
  assign cpu_stall_o = stall_q;
  assign load_done_o = done_q;
  assign load_err_o  = err_q;
  assign checksum_o  = csum_q;

  // State and datapath registers; synchronous reset, memory contents are not rolled back.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      stall_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      stall_q <= stall_d;
      done_q  <= done_d;
      err_q   <= err_d;
      csum_q  <= csum_d;
    end
  end

  // Next-state and output decode: start handling, stream writes, word padding, release.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    stall_d = stall_q;
    done_d  = done_q;
    err_d   = err_q;
    csum_d  = csum_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        // Release is one cycle after entering DONE so the last write lands first.
        if (state_q == DONE) begin
          done_d  = 1'b1;
          stall_d = 1'b0;
        end
        if (start_i) begin
          done_d  = 1'b0;
          stall_d = 1'b1;
          if ((prog_len_i == '0) || (prog_len_i > MAX_LEN)) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d = LOAD;
            err_d   = 1'b0;
            len_d   = prog_len_i;
            cnt_d   = '0;
            csum_d  = '0;
          end
        end
      end

      LOAD: begin
        if (byte_valid_i) begin
          we_d    = 1'b1;
          waddr_d = cnt_q[ADDR_W-1:0];
          wdata_d = byte_data_i;
          cnt_d   = cnt_inc;
          csum_d  = csum_q + byte_data_i;
          if (cnt_inc == len_q) begin
            state_d = (cnt_inc[1:0] == 2'b00) ? DONE : PAD;
          end
        end
      end

      PAD: begin
        we_d    = 1'b1;
        waddr_d = cnt_q[ADDR_W-1:0];
        wdata_d = NOP_BYTE;
        cnt_d   = cnt_inc;
        if (cnt_inc[1:0] == 2'b00) begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for the boot loader: full-word load, padded load, rejected lengths,
// valid gaps, mid-load reset, and start during LOAD / in DONE.
// Memory writes are captured by a small byte-array model clocked like the real memory.
module tb_imem_boot_loader;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [8:0] prog_len_i;
  logic       byte_valid_i;
  logic [7:0] byte_data_i;
  logic       byte_ready_o;
  logic       mem_we_o;
  logic [7:0] mem_waddr_o;
  logic [7:0] mem_wdata_o;
  logic       cpu_stall_o;
  logic       load_done_o;
  logic       load_err_o;
  logic [7:0] checksum_o;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] mem_model [256];
  int         wr_cnt = 0;
  int         wr_base;

  logic [7:0] b1 [8];
  logic [7:0] d3 [4];
  logic [6:0] pat;
  int         k;

  imem_boot_loader dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .prog_len_i   (prog_len_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .mem_we_o     (mem_we_o),
    .mem_waddr_o  (mem_waddr_o),
    .mem_wdata_o  (mem_wdata_o),
    .cpu_stall_o  (cpu_stall_o),
    .load_done_o  (load_done_o),
    .load_err_o   (load_err_o),
    .checksum_o   (checksum_o)
  );

  always #5 clk_i = ~clk_i;

  // Behaves like the instruction memory write port: captures the registered write at each edge.
  always @(posedge clk_i) begin
    if (mem_we_o === 1'b1) begin
      mem_model[mem_waddr_o] = mem_wdata_o;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, byte_ready_o, 0);
    chk({tag, "_we"},    mem_we_o,     0);
    chk({tag, "_waddr"}, mem_waddr_o,  0);
    chk({tag, "_wdata"}, mem_wdata_o,  0);
    chk({tag, "_stall"}, cpu_stall_o,  1);
    chk({tag, "_done"},  load_done_o,  0);
    chk({tag, "_err"},   load_err_o,   0);
    chk({tag, "_csum"},  checksum_o,   0);
  endtask

  initial begin
    b1[0] = 8'h80; b1[1] = 8'h20; b1[2] = 8'h00; b1[3] = 8'h0A;
    b1[4] = 8'h00; b1[5] = 8'h00; b1[6] = 8'h00; b1[7] = 8'h00;
    d3[0] = 8'h11; d3[1] = 8'h22; d3[2] = 8'h33; d3[3] = 8'h44;
    pat = 7'b1011001;   // bit i is byte_valid in cycle i: 1,0,0,1,1,0,1

    rst_i = 1'b1; start_i = 1'b0; prog_len_i = '0; byte_valid_i = 1'b0; byte_data_i = '0;
    step(); step();
    chk_reset_vals("rst");
    rst_i = 1'b0;
    step();
    chk_reset_vals("idle");

    // ---- 8-byte load, word aligned, no padding ----
    start_i = 1'b1; prog_len_i = 9'd8;
    step();
    start_i = 1'b0;
    chk("t1_ready", byte_ready_o, 1);
    chk("t1_stall", cpu_stall_o, 1);
    for (int i = 0; i < 8; i++) begin
      byte_valid_i = 1'b1; byte_data_i = b1[i];
      step();
      chk("t1_we", mem_we_o, 1);
      chk("t1_waddr", mem_waddr_o, i);
      chk("t1_wdata", mem_wdata_o, b1[i]);
    end
    byte_valid_i = 1'b0;
    chk("t1_done_not_yet", load_done_o, 0);
    chk("t1_stall_held", cpu_stall_o, 1);
    step();
    chk("t1_no_pad_we", mem_we_o, 0);
    chk("t1_done", load_done_o, 1);
    chk("t1_release", cpu_stall_o, 0);
    chk("t1_csum", checksum_o, 8'hAA);
    chk("t1_mem3", mem_model[3], 8'h0A);

    // ---- 6-byte load, padded with two NOPs (start from DONE) ----
    wr_base = wr_cnt;
    start_i = 1'b1; prog_len_i = 9'd6;
    step();
    start_i = 1'b0;
    chk("t2_stall_reasserted", cpu_stall_o, 1);
    for (int i = 0; i < 6; i++) begin
      byte_valid_i = 1'b1; byte_data_i = 8'(i + 1);
      step();
      chk("t2_waddr", mem_waddr_o, i);
    end
    byte_valid_i = 1'b0;
    chk("t2_pad_ready", byte_ready_o, 0);
    step();
    chk("t2_pad6_we", mem_we_o, 1);
    chk("t2_pad6_addr", mem_waddr_o, 6);
    chk("t2_pad6_data", mem_wdata_o, 0);
    step();
    chk("t2_pad7_addr", mem_waddr_o, 7);
    chk("t2_pad7_data", mem_wdata_o, 0);
    chk("t2_done_not_yet", load_done_o, 0);
    step();
    chk("t2_done", load_done_o, 1);
    chk("t2_release", cpu_stall_o, 0);
    chk("t2_csum", checksum_o, 8'h15);
    chk("t2_writes", wr_cnt - wr_base, 8);
    chk("t2_mem5", mem_model[5], 8'h06);

    // ---- rejected lengths 0 and 257 ----
    wr_base = wr_cnt;
    start_i = 1'b1; prog_len_i = 9'd0;
    step();
    start_i = 1'b0;
    chk("t3_len0_err", load_err_o, 1);
    chk("t3_len0_stall", cpu_stall_o, 1);
    chk("t3_len0_done", load_done_o, 0);
    chk("t3_len0_ready", byte_ready_o, 0);
    byte_valid_i = 1'b1;
    step(); step();
    byte_valid_i = 1'b0;
    chk("t3_len0_we", mem_we_o, 0);
    chk("t3_len0_writes", wr_cnt - wr_base, 0);
    start_i = 1'b1; prog_len_i = 9'd257;
    step();
    start_i = 1'b0;
    chk("t3_len257_err", load_err_o, 1);
    chk("t3_len257_stall", cpu_stall_o, 1);
    step(); step();
    chk("t3_len257_writes", wr_cnt - wr_base, 0);

    // ---- valid start clears the error; byte_valid with gaps ----
    start_i = 1'b1; prog_len_i = 9'd4;
    step();
    start_i = 1'b0;
    chk("t4_err_cleared", load_err_o, 0);
    chk("t4_ready", byte_ready_o, 1);
    k = 0;
    for (int i = 0; i < 7; i++) begin
      byte_valid_i = pat[i];
      byte_data_i  = pat[i] ? d3[k] : 8'hEE;
      step();
      chk("t4_we_follows_valid", mem_we_o, pat[i]);
      if (pat[i]) begin
        chk("t4_waddr", mem_waddr_o, k);
        k++;
      end
    end
    byte_valid_i = 1'b0;
    step();
    chk("t4_done", load_done_o, 1);
    chk("t4_writes", wr_cnt - wr_base, 4);
    chk("t4_mem0", mem_model[0], 8'h11);
    chk("t4_mem3", mem_model[3], 8'h44);

    // ---- reset after 3 of 8 bytes, then fresh reload ----
    start_i = 1'b1; prog_len_i = 9'd8;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      byte_valid_i = 1'b1; byte_data_i = 8'hA1 + 8'(i);
      step();
    end
    byte_valid_i = 1'b0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk_reset_vals("midrst");
    chk("t5_kept_mem2", mem_model[2], 8'hA3);
    start_i = 1'b1; prog_len_i = 9'd8;
    step();
    start_i = 1'b0;
    byte_valid_i = 1'b1; byte_data_i = 8'hB0;
    step();
    chk("t5_restart_addr", mem_waddr_o, 0);
    chk("t5_restart_data", mem_wdata_o, 8'hB0);
    for (int i = 1; i < 8; i++) begin
      byte_data_i = 8'hB0 + 8'(i);
      step();
    end
    byte_valid_i = 1'b0;
    step();
    chk("t5_done", load_done_o, 1);
    chk("t5_mem7", mem_model[7], 8'hB7);

    // ---- start during LOAD is ignored; start in DONE restarts ----
    wr_base = wr_cnt;
    start_i = 1'b1; prog_len_i = 9'd8;
    step();
    for (int i = 0; i < 8; i++) begin
      start_i = (i == 2);
      prog_len_i = (i == 2) ? 9'd4 : 9'd8;
      byte_valid_i = 1'b1; byte_data_i = 8'h10 + 8'(i);
      step();
      chk("t6_waddr", mem_waddr_o, i);
      if (i == 3) chk("t6_still_loading", byte_ready_o, 1);
    end
    start_i = 1'b0; byte_valid_i = 1'b0;
    step();
    chk("t6_done", load_done_o, 1);
    chk("t6_csum", checksum_o, 8'h9C);
    chk("t6_writes", wr_cnt - wr_base, 8);
    start_i = 1'b1; prog_len_i = 9'd4;
    step();
    start_i = 1'b0;
    chk("t6_restart_stall", cpu_stall_o, 1);
    chk("t6_restart_done", load_done_o, 0);
    chk("t6_restart_ready", byte_ready_o, 1);
    chk("t6_restart_csum", checksum_o, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sequences the programming of the byte-wide instruction memory from a byte stream (UART/debug bridge) at boot.
- Holds the CPU fetch stage stalled until the program is fully written and padded to a word boundary.
- Sits between the host byte source and the instruction memory write port; the CPU fetch/read path is untouched.
- Instruction words are big-endian: byte at address 4k is the MSB of word k. The loader writes bytes in arrival order from address 0.

Parameters:
- INSTR_MEM_SIZE, 256, instruction memory depth in bytes; power of two.
- MEM_CELL_SIZE, 8, bits per memory cell. Fixed at 8; any other value is unsupported.
- ADDR_W, $clog2(INSTR_MEM_SIZE), byte address width. Derived; not to be overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; begins a load. Honoured only in IDLE, DONE or ERR.
- prog_len  in  ADDR_W+1  program length in bytes; sampled on the accepted start.
- byte_valid  in  1  source has a byte on byte_data
- byte_data  in  8  program byte
- byte_ready  out  1  loader accepts byte_data this cycle
- mem_we  out  1  instruction memory byte write enable (registered)
- mem_waddr  out  ADDR_W  byte write address (registered)
- mem_wdata  out  8  byte write data (registered)
- cpu_stall  out  1  CPU fetch hold; high until a successful load completes
- load_done  out  1  level; program loaded and padded
- load_err  out  1  level; prog_len was rejected
- checksum  out  8  sum mod 256 of accepted stream bytes; pad bytes are excluded

Behaviour:
- Reset values: state IDLE, byte_ready 0, mem_we 0, mem_waddr 0, mem_wdata 0, cpu_stall 1, load_done 0, load_err 0, checksum 0, internal count 0.
- rst mid-load: same reset values on the next edge. Bytes already written stay in memory; no rollback.
- FSM states: IDLE, LOAD, PAD, DONE, ERR.
- IDLE/DONE/ERR + start:
  - prog_len == 0 or prog_len > INSTR_MEM_SIZE -> ERR: load_err=1, load_done=0, cpu_stall=1.
  - Otherwise -> LOAD: latch length, clear count and checksum, load_done=0, load_err=0, cpu_stall=1.
- start is ignored in LOAD and PAD.
- LOAD:
  - byte_ready=1, combinational from state only; it does not depend on byte_valid.
  - An accept is a cycle where byte_valid && byte_ready.
  - On accept, the next edge sets mem_we=1, mem_waddr=count, mem_wdata=byte_data. count increments and checksum += byte_data (8-bit wrap).
  - Write latency is 1 cycle from accept.
  - Gaps in byte_valid insert no writes (mem_we=0 that cycle).
  - On the accept where count+1 == length:
    - (count+1) mod 4 == 0 -> DONE.
    - Otherwise -> PAD.
- PAD:
  - byte_ready=0.
  - Each cycle writes 0x00 (NOP byte) at mem_waddr=count and increments count. Checksum is unchanged.
  - Leaves for DONE after the write that makes count mod 4 == 0.
  - At most 3 pad cycles.
  - Pad never exceeds memory, because INSTR_MEM_SIZE is a multiple of 4.
- Entering DONE (same edge as the last write): load_done=1 and cpu_stall=0 take effect the following cycle. The final write is therefore visible before the CPU is released.
- DONE: holds until start or rst. A new start re-asserts cpu_stall immediately (registered, next edge).
- ERR: no writes; byte_ready=0. Exits only on a valid start or rst.
- Address arithmetic: count is ADDR_W+1 bits; mem_waddr = count[ADDR_W-1:0]. No wrap is possible given the length check.

Decomposition:
- Shared package imem_pkg:
  - INSTR_MEM_SIZE, MEM_CELL_SIZE, NOP_BYTE=8'h00.
  - typedef enum logic [2:0] boot_state_t {IDLE, LOAD, PAD, DONE, ERR}.
- No sub-module; a single FSM plus datapath is sufficient.
- The instruction memory gains a byte write port, driven by mem_we/mem_waddr/mem_wdata, in a separate change.

Test Plan:
- Load 8 bytes 0x80,0x20,0x00,0x0A,0x00,0x00,0x00,0x00 with byte_valid held high:
  - writes to addresses 0..7 appear one cycle after each accept;
  - checksum = 0xAA; no PAD cycles;
  - load_done=1 and cpu_stall=0 one cycle after the address-7 write.
- prog_len=6, bytes 0x01..0x06:
  - six stream writes, then 0x00 written to addresses 6 and 7 with byte_ready=0;
  - checksum = 0x15; load_done after address 7.
- prog_len=0, then prog_len=257 (size 256):
  - ERR each time: load_err=1, no mem_we, cpu_stall=1.
  - A subsequent valid start with prog_len=4 clears load_err.
- prog_len=4 with byte_valid toggling 1,0,0,1,1,0,1:
  - exactly 4 writes at addresses 0..3, with no write in gap cycles.
- rst asserted after 3 of 8 bytes:
  - all outputs return to reset values next edge;
  - a fresh start with prog_len=8 rewrites from address 0.
- start pulsed during LOAD: ignored, count and length unchanged; start in DONE restarts the load with cpu_stall=1.
